// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared definitions for the ALU sequencer: ALU opcode values, the
//   sequencer state type and the bit positions of the instruction fields.
//   Instruction word layout:
//     [15]    li    load-immediate flag
//     [14:12] op    ALU opcode
//     [11:10] rd    destination / first operand register
//     [9:8]   rs    second operand register
//     [7:0]   imm8  immediate value or signed branch offset
package alu_seq_pkg;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_NOT  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_SRA  = 3'd4;
    localparam logic [2:0] ALU_SLL  = 3'd5;
    localparam logic [2:0] ALU_BEQ  = 3'd6;
    localparam logic [2:0] ALU_BNEQ = 3'd7;

    localparam int LI_BIT  = 15;
    localparam int OP_MSB  = 14;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RS_MSB  = 9;
    localparam int RS_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        WB    = 2'd2
    } seq_state_t;

    // Arithmetic/logic opcodes write their result back; the two branch
    // opcodes only steer the PC.
    function automatic logic op_writes_reg(input logic [2:0] op);
        logic writes;
        case (op)
            ALU_ADD, ALU_NOT, ALU_AND, ALU_OR, ALU_SRA, ALU_SLL: writes = 1'b1;
            ALU_BEQ, ALU_BNEQ:                                   writes = 1'b0;
            default:                                             writes = 1'b0;
        endcase
        return writes;
    endfunction

endpackage

// File: rtl/seq_regfile.sv
// seq_regfile
//   4 x 8-bit register file for the ALU sequencer.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low clear of all entries
//     raddr_a / rdata_a   combinational read port A
//     raddr_b / rdata_b   combinational read port B
//     we, waddr, wdata    synchronous write port
module seq_regfile (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] raddr_a,
    output logic [7:0] rdata_a,
    input  logic [1:0] raddr_b,
    output logic [7:0] rdata_b,
    input  logic       we,
    input  logic [1:0] waddr,
    input  logic [7:0] wdata
);

    logic [7:0] regs [4];

    // Storage with a single write port; all entries clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Multi-cycle fetch / execute / writeback core driving an external,
//   purely combinational 8-bit ALU.
//   Parameters: PC_W (PC / instruction address width), RESET_PC.
//   Ports:
//     clk, rst_n                     clock, asynchronous active-low reset
//     run                            level enable for fetching
//     instr_req, instr_addr          instruction fetch request and address (PC)
//     instr_rdata, instr_valid       instruction word and response strobe
//     alu_a, alu_b, alu_sel          ALU operands R[rd], R[rs] and opcode
//     alu_f, alu_ovf, alu_take_branch ALU result, add overflow, branch decision
//     ovf_flag                       sticky add overflow
//     busy                           low only while parked in FETCH with run=0
//   Optional feature (macro SEQ_RETIRE_EN): adds retire_valid / retire_pc,
//   a one-cycle pulse after each writeback carrying the retired PC.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    output logic            instr_req,
    output logic [PC_W-1:0] instr_addr,
    input  logic [15:0]     instr_rdata,
    input  logic            instr_valid,
    output logic [7:0]      alu_a,
    output logic [7:0]      alu_b,
    output logic [2:0]      alu_sel,
    input  logic [7:0]      alu_f,
    input  logic            alu_ovf,
    input  logic            alu_take_branch,
    output logic            ovf_flag,
    output logic            busy
`ifdef SEQ_RETIRE_EN
    ,
    output logic            retire_valid,
    output logic [PC_W-1:0] retire_pc
`endif
);

    seq_state_t      state;
    logic [PC_W-1:0] pc;
    logic            li_q;
    logic [1:0]      rd_q;
    logic [7:0]      imm_q;
    logic [7:0]      f_q;
    logic            ovf_q;
    logic            take_q;
    logic            accept;
    logic [7:0]      rdata_a;
    logic [7:0]      rdata_b;
    logic            rf_we;
    logic [7:0]      rf_wdata;

    // Request and busy are gated by rst_n so both read 0 while reset is held,
    // even if run is high.
    assign instr_req  = rst_n && (state == FETCH) && run;
    assign busy       = rst_n && !((state == FETCH) && !run);
    assign accept     = instr_req && instr_valid;
    assign instr_addr = pc;

    assign rf_we    = (state == WB) && (li_q || op_writes_reg(alu_sel));
    assign rf_wdata = li_q ? imm_q : f_q;

    // Operands are read straight from the incoming word so they can be
    // registered onto alu_a/alu_b in the same edge that enters EXEC.
    seq_regfile u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .raddr_a (instr_rdata[RD_MSB:RD_LSB]),
        .rdata_a (rdata_a),
        .raddr_b (instr_rdata[RS_MSB:RS_LSB]),
        .rdata_b (rdata_b),
        .we      (rf_we),
        .waddr   (rd_q),
        .wdata   (rf_wdata)
    );

    // Main sequencer. alu_sel doubles as the captured opcode; the ALU
    // outputs are sampled at the end of EXEC and consumed in WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            li_q     <= 1'b0;
            rd_q     <= '0;
            imm_q    <= '0;
            f_q      <= '0;
            ovf_q    <= 1'b0;
            take_q   <= 1'b0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sel  <= '0;
            ovf_flag <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (accept) begin
                        li_q    <= instr_rdata[LI_BIT];
                        rd_q    <= instr_rdata[RD_MSB:RD_LSB];
                        imm_q   <= instr_rdata[IMM_MSB:IMM_LSB];
                        alu_sel <= instr_rdata[OP_MSB:OP_LSB];
                        alu_a   <= rdata_a;
                        alu_b   <= rdata_b;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    f_q    <= alu_f;
                    ovf_q  <= alu_ovf;
                    take_q <= alu_take_branch;
                    state  <= WB;
                end
                WB: begin
                    if (li_q || op_writes_reg(alu_sel)) begin
                        pc <= pc + PC_W'(1);
                        if (!li_q && (alu_sel == ALU_ADD) && ovf_q) begin
                            ovf_flag <= 1'b1;
                        end
                    end else if (take_q) begin
                        pc <= pc + PC_W'($signed(imm_q));
                    end else begin
                        pc <= pc + PC_W'(1);
                    end
                    state <= FETCH;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

`ifdef SEQ_RETIRE_EN
    // Retire pulse follows WB by one cycle; pc still holds the retired
    // instruction's address at the WB edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_valid <= 1'b0;
            retire_pc    <= '0;
        end else begin
            retire_valid <= (state == WB);
            if (state == WB) begin
                retire_pc <= pc;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
//   Bench for alu_sequencer: instruction memory model, combinational ALU
//   model, an instruction-level reference model feeding a scoreboard, and a
//   monitor that checks every fetch and execute cycle against it.
//   Honours SEQ_RETIRE_EN when defined.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        instr_req;
    logic [7:0]  instr_addr;
    logic [15:0] instr_rdata;
    logic        instr_valid;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_sel;
    logic [7:0]  alu_f;
    logic        alu_ovf;
    logic        alu_take_branch;
    logic        ovf_flag;
    logic        busy;
`ifdef SEQ_RETIRE_EN
    logic        retire_valid;
    logic [7:0]  retire_pc;
`endif

    typedef struct {
        int pc;
        int a;
        int b;
        int sel;
    } exp_t;

    exp_t        exp_q[$];
    int          ret_q[$];
    exp_t        cur;
    logic [15:0] mem [256];
    int          mem_mode;
    int          hold_cycles;
    int          hs_count;
    bit          exec_pending;
    int          final_pc;
    int          final_ovf;
    int          total;
    int          bad;

    always #5 clk = ~clk;

    alu_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .run             (run),
        .instr_req       (instr_req),
        .instr_addr      (instr_addr),
        .instr_rdata     (instr_rdata),
        .instr_valid     (instr_valid),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_sel         (alu_sel),
        .alu_f           (alu_f),
        .alu_ovf         (alu_ovf),
        .alu_take_branch (alu_take_branch),
        .ovf_flag        (ovf_flag),
        .busy            (busy)
`ifdef SEQ_RETIRE_EN
        ,
        .retire_valid    (retire_valid),
        .retire_pc       (retire_pc)
`endif
    );

    // Combinational ALU seen by the DUT.
    always_comb begin
        alu_f           = '0;
        alu_ovf         = 1'b0;
        alu_take_branch = 1'b0;
        case (alu_sel)
            3'd0: begin
                alu_f   = alu_a + alu_b;
                alu_ovf = (alu_a[7] == alu_b[7]) && (alu_f[7] != alu_a[7]);
            end
            3'd1: alu_f = ~alu_a;
            3'd2: alu_f = alu_a & alu_b;
            3'd3: alu_f = alu_a | alu_b;
            3'd4: alu_f = 8'($signed(alu_a) >>> 1);
            3'd5: alu_f = alu_a << 1;
            3'd6: alu_take_branch = (alu_a == alu_b);
            3'd7: alu_take_branch = (alu_a != alu_b);
            default: alu_f = '0;
        endcase
    end

    // Instruction memory: mode 0 zero-wait, 1 random wait, 2 valid always high.
    always @(posedge clk) begin
        #2;
        instr_rdata = mem[instr_addr];
        if (hold_cycles > 0) begin
            instr_valid = 1'b0;
            hold_cycles--;
        end else if (mem_mode == 2) begin
            instr_valid = 1'b1;
        end else if (mem_mode == 1) begin
            instr_valid = instr_req && ($urandom_range(0, 2) == 0);
        end else begin
            instr_valid = instr_req;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [15:0] enc(input int li, input int op, input int rd,
                                        input int rs, input int imm);
        logic [15:0] w;
        w = {1'(li), 3'(op), 2'(rd), 2'(rs), 8'(imm)};
        return w;
    endfunction

    function automatic int sx(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // Instruction-level model: executes n instructions from PC 0 with cleared
    // registers and queues what each fetch/execute/retire must look like.
    task automatic refModel(input int n);
        int r[4];
        int pc;
        int ovf;
        r   = '{0, 0, 0, 0};
        pc  = 0;
        ovf = 0;
        for (int k = 0; k < n; k++) begin
            logic [15:0] w;
            int li, op, rd, rs, imm, a, b, s, sa;
            exp_t e;
            w   = mem[pc];
            li  = int'(w[15]);
            op  = int'(w[14:12]);
            rd  = int'(w[11:10]);
            rs  = int'(w[9:8]);
            imm = int'(w[7:0]);
            a   = r[rd];
            b   = r[rs];
            e.pc = pc; e.a = a; e.b = b; e.sel = op;
            exp_q.push_back(e);
            ret_q.push_back(pc);
            if (li != 0) begin
                r[rd] = imm;
                pc = (pc + 1) % 256;
            end else if (op < 6) begin
                s = 0;
                case (op)
                    0: begin
                        s  = a + b;
                        sa = sx(a) + sx(b);
                        if (sa > 127 || sa < -128) ovf = 1;
                    end
                    1: s = 255 - a;
                    2: s = a & b;
                    3: s = a | b;
                    4: begin
                        sa = sx(a);
                        s  = (sa - (sa & 1)) / 2;
                    end
                    default: s = a * 2;
                endcase
                r[rd] = s & 255;
                pc = (pc + 1) % 256;
            end else begin
                if ((op == 6) ? (a == b) : (a != b)) pc = (pc + sx(imm) + 256) % 256;
                else pc = (pc + 1) % 256;
            end
        end
        final_pc  = pc;
        final_ovf = ovf;
    endtask

    // Monitor: pops the scoreboard on every accepted fetch, checks operands
    // in the following EXEC cycle, and checks retire pulses when present.
    always @(negedge clk) begin
        if (!rst_n) begin
            exec_pending = 1'b0;
        end else begin
            if (exec_pending) begin
                checkOutput("exec_a", alu_a, cur.a);
                checkOutput("exec_b", alu_b, cur.b);
                checkOutput("exec_sel", alu_sel, cur.sel);
                checkOutput("exec_req_low", instr_req, 0);
                exec_pending = 1'b0;
            end
            if (instr_req && instr_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_fetch: got addr 0x%0h, expected none", instr_addr);
                end else begin
                    cur = exp_q.pop_front();
                    checkOutput("fetch_pc", instr_addr, cur.pc);
                    exec_pending = 1'b1;
                end
                hs_count++;
            end
`ifdef SEQ_RETIRE_EN
            if (retire_valid) begin
                if (ret_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_retire: got pc 0x%0h, expected none", retire_pc);
                end else begin
                    checkOutput("retire_pc", retire_pc, ret_q.pop_front());
                end
            end
`endif
        end
    end

    task automatic clearMem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    endtask

    task automatic applyReset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        run   = 1'b0;
        exp_q.delete();
        ret_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Runs n instructions from reset, optionally holding instr_valid low for
    // the first 'hold' cycles and checking the PC after cyc_check cycles.
    task automatic applyStimulus(input int n, input int hold, input int cyc_check,
                                 input int pc_check);
        int target;
        int cyc;
        refModel(n);
        target = hs_count + n;
        cyc = 0;
        @(posedge clk);
        #1;
        hold_cycles = hold;
        run = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            if (cyc < hold) begin
                checkOutput("hold_req", instr_req, 1);
                checkOutput("hold_busy", busy, 1);
                checkOutput("hold_pc", instr_addr, 0);
            end
            if (cyc == cyc_check) checkOutput("pc_at_cycle", instr_addr, pc_check);
            if (hs_count >= target) break;
            if (cyc > n * 40 + 40) begin
                total++;
                bad++;
                $display("[TB] FAIL fetch_timeout: got %0d fetches, expected %0d", hs_count, target);
                break;
            end
            @(posedge clk);
            cyc++;
        end
        @(posedge clk);
        #1;
        run = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        checkOutput("parked_busy", busy, 0);
        checkOutput("final_pc", instr_addr, final_pc);
        checkOutput("final_ovf", ovf_flag, final_ovf);
        checkOutput("pending_fetches", exp_q.size(), 0);
`ifdef SEQ_RETIRE_EN
        checkOutput("pending_retires", ret_q.size(), 0);
`endif
    endtask

    initial begin
        int target;
        int cnt;
        total = 0;
        bad = 0;
        hs_count = 0;
        exec_pending = 1'b0;
        rst_n = 1'b0;
        run = 1'b0;
        mem_mode = 0;
        hold_cycles = 0;
        instr_valid = 1'b0;
        instr_rdata = '0;
        clearMem();

        // Reset values.
        applyReset();
        @(negedge clk);
        checkOutput("rst_req", instr_req, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_pc", instr_addr, 0);
        checkOutput("rst_alu_a", alu_a, 0);
        checkOutput("rst_alu_sel", alu_sel, 0);
        checkOutput("rst_ovf", ovf_flag, 0);

        // LI R1,0x7F; LI R2,1; ADD R1,R2; OR R1,R1 (shows R1=0x80).
        $display("[TB] overflow program");
        mem[0] = enc(1, 0, 1, 0, 'h7F);
        mem[1] = enc(1, 0, 2, 0, 'h01);
        mem[2] = enc(0, 0, 1, 2, 0);
        mem[3] = enc(0, 3, 1, 1, 0);
        applyStimulus(4, 0, 9, 3);
        checkOutput("ovf_sticky", ovf_flag, 1);

        // Reset in the EXEC cycle of an overflowing ADD.
        $display("[TB] reset mid-exec");
        applyReset();
        clearMem();
        mem[0] = enc(1, 0, 1, 0, 'h7F);
        mem[1] = enc(0, 0, 1, 1, 0);
        refModel(2);
        target = hs_count + 2;
        cnt = 0;
        @(posedge clk);
        #1;
        run = 1'b1;
        while (hs_count < target && cnt < 100) begin
            @(negedge clk);
            #1;
            cnt++;
        end
        checkOutput("rst_test_fetches", hs_count, target);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_req", instr_req, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_pc", instr_addr, 0);
        checkOutput("midrst_alu_a", alu_a, 0);
        checkOutput("midrst_alu_b", alu_b, 0);
        checkOutput("midrst_ovf", ovf_flag, 0);
`ifdef SEQ_RETIRE_EN
        checkOutput("midrst_retire", retire_valid, 0);
`endif
        run = 1'b0;
        exp_q.delete();
        ret_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem[0] = enc(0, 3, 1, 1, 0);
        applyStimulus(1, 0, -1, 0);

        // BEQ taken backwards, with instr_valid held off for 4 cycles.
        $display("[TB] branch equal taken");
        applyReset();
        clearMem();
        mem[0] = enc(1, 0, 0, 0, 5);
        mem[1] = enc(1, 0, 3, 0, 5);
        mem[2] = enc(0, 6, 0, 3, 'hFC);
        applyStimulus(3, 4, -1, 0);
        checkOutput("beq_taken_pc", instr_addr, 'hFE);

        $display("[TB] branch equal not taken");
        applyReset();
        mem[1] = enc(1, 0, 3, 0, 6);
        applyStimulus(3, 0, -1, 0);
        checkOutput("beq_not_taken_pc", instr_addr, 3);

        // BNEQ to 0xFF, then BNEQ +2 wraps to 0x01.
        $display("[TB] pc wrap");
        applyReset();
        clearMem();
        mem_mode = 1;
        mem[0]   = enc(1, 0, 0, 0, 1);
        mem[1]   = enc(0, 7, 0, 1, 'hFE);
        mem[255] = enc(0, 7, 0, 1, 2);
        applyStimulus(3, 0, -1, 0);
        checkOutput("wrap_pc", instr_addr, 1);

        // Self-loop with instr_valid stuck high outside FETCH.
        $display("[TB] self loop, valid always high");
        applyReset();
        clearMem();
        mem_mode = 2;
        mem[0] = enc(0, 6, 0, 0, 0);
        applyStimulus(3, 0, -1, 0);
        checkOutput("self_loop_pc", instr_addr, 0);

        // Random programs with random wait states.
        mem_mode = 1;
        for (int round = 0; round < 3; round++) begin
            $display("[TB] random round %0d", round);
            applyReset();
            for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
            applyStimulus(30, 0, -1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
